// File: rtl/mqnic_rx_queue_map_req.sv
// RX queue mapper initiator: tags per-packet lookup requests, collects the
// out-of-order tagged responses and releases results in request order.
module mqnic_rx_queue_map_req #(
  parameter int PORTS             = 1,
  parameter int QUEUE_INDEX_WIDTH = 10,
  parameter int ID_WIDTH          = (PORTS > 1) ? $clog2(PORTS) : 1,
  parameter int DEST_WIDTH        = QUEUE_INDEX_WIDTH + 1,
  parameter int HASH_WIDTH        = 32,
  parameter int TAG_WIDTH         = 4,
  parameter int USER_WIDTH        = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,

  input  logic [ID_WIDTH-1:0]          s_req_id,
  input  logic [DEST_WIDTH-1:0]        s_req_dest,
  input  logic [HASH_WIDTH-1:0]        s_req_hash,
  input  logic [USER_WIDTH-1:0]        s_req_user,
  input  logic                         s_req_valid,
  output logic                         s_req_ready,

  output logic [ID_WIDTH-1:0]          m_map_req_id,
  output logic [DEST_WIDTH-1:0]        m_map_req_dest,
  output logic [HASH_WIDTH-1:0]        m_map_req_hash,
  output logic [TAG_WIDTH-1:0]         m_map_req_tag,
  output logic                         m_map_req_valid,

  input  logic [QUEUE_INDEX_WIDTH-1:0] s_map_resp_queue,
  input  logic [TAG_WIDTH-1:0]         s_map_resp_tag,
  input  logic                         s_map_resp_valid,

  output logic [QUEUE_INDEX_WIDTH-1:0] m_queue,
  output logic [USER_WIDTH-1:0]        m_user,
  output logic                         m_valid,
  input  logic                         m_ready,

  output logic [TAG_WIDTH:0]           outstanding,
  output logic                         stat_unexp_resp
);

  localparam int DEPTH = 2 ** TAG_WIDTH;
  localparam logic [TAG_WIDTH:0] FULL = (TAG_WIDTH + 1)'(DEPTH);

  logic [TAG_WIDTH-1:0]         head;
  logic [TAG_WIDTH-1:0]         tail;
  logic [TAG_WIDTH:0]           count;
  logic [DEPTH-1:0]             pending;
  logic [DEPTH-1:0]             done;
  logic [USER_WIDTH-1:0]        ctx_mem   [DEPTH];
  logic [QUEUE_INDEX_WIDTH-1:0] queue_mem [DEPTH];

  logic accept;
  logic release_en;
  logic resp_ok;

  // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
  always_comb begin
    accept     = s_req_valid && s_req_ready;
    release_en = done[tail] && m_ready;
    resp_ok    = s_map_resp_valid && pending[s_map_resp_tag] && !done[s_map_resp_tag];
  end

  assign s_req_ready = (count != FULL);
  assign outstanding = count;
  assign m_valid     = done[tail];
  assign m_queue     = queue_mem[tail];
  assign m_user      = ctx_mem[tail];

  // Release clears before accept sets, so a slot freed and reused in one cycle ends up pending.
  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      pending         <= '0;
      done            <= '0;
      m_map_req_valid <= 1'b0;
      stat_unexp_resp <= 1'b0;
    end else begin
      if (resp_ok) begin
        done[s_map_resp_tag] <= 1'b1;
      end
      if (release_en) begin
        pending[tail] <= 1'b0;
        done[tail]    <= 1'b0;
        tail          <= tail + TAG_WIDTH'(1);
      end
      if (accept) begin
        pending[head] <= 1'b1;
        done[head]    <= 1'b0;
        head          <= head + TAG_WIDTH'(1);
      end
      case ({accept, release_en})
        2'b10:   count <= count + (TAG_WIDTH + 1)'(1);
        2'b01:   count <= count - (TAG_WIDTH + 1)'(1);
        default: count <= count;
      endcase
      m_map_req_valid <= accept;
      stat_unexp_resp <= s_map_resp_valid && !resp_ok;
    end
  end

  // NOTE: payload storage is not reset; the pending/done bits alone decide whether it is meaningful.
  always_ff @(posedge clk) begin
    if (accept) begin
      ctx_mem[head]  <= s_req_user;
      m_map_req_id   <= s_req_id;
      m_map_req_dest <= s_req_dest;
      m_map_req_hash <= s_req_hash;
      m_map_req_tag  <= head;
    end
    if (resp_ok) begin
      queue_mem[s_map_resp_tag] <= s_map_resp_queue;
    end
  end

endmodule

// File: tb/tb_mqnic_rx_queue_map_req.sv
// Bench for mqnic_rx_queue_map_req: directed scenarios plus a randomized run,
// all checked every cycle against an ordered-list model of outstanding requests.
module tb_mqnic_rx_queue_map_req;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [0:0]  s_req_id = '0;
  logic [10:0] s_req_dest = '0;
  logic [31:0] s_req_hash = '0;
  logic [15:0] s_req_user = '0;
  logic        s_req_valid = 1'b0;
  logic        s_req_ready;
  logic [0:0]  m_map_req_id;
  logic [10:0] m_map_req_dest;
  logic [31:0] m_map_req_hash;
  logic [3:0]  m_map_req_tag;
  logic        m_map_req_valid;
  logic [9:0]  s_map_resp_queue = '0;
  logic [3:0]  s_map_resp_tag = '0;
  logic        s_map_resp_valid = 1'b0;
  logic [9:0]  m_queue;
  logic [15:0] m_user;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [4:0]  outstanding;
  logic        stat_unexp_resp;

  mqnic_rx_queue_map_req dut (
    .clk(clk), .rst_n(rst_n),
    .s_req_id(s_req_id), .s_req_dest(s_req_dest), .s_req_hash(s_req_hash),
    .s_req_user(s_req_user), .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .m_map_req_id(m_map_req_id), .m_map_req_dest(m_map_req_dest),
    .m_map_req_hash(m_map_req_hash), .m_map_req_tag(m_map_req_tag),
    .m_map_req_valid(m_map_req_valid),
    .s_map_resp_queue(s_map_resp_queue), .s_map_resp_tag(s_map_resp_tag),
    .s_map_resp_valid(s_map_resp_valid),
    .m_queue(m_queue), .m_user(m_user), .m_valid(m_valid), .m_ready(m_ready),
    .outstanding(outstanding), .stat_unexp_resp(stat_unexp_resp)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: outstanding requests as an ordered list; tags are the issue index mod 16.
  typedef struct {
    logic [3:0]  tag;
    logic [15:0] user;
    bit          resolved;
    logic [9:0]  q;
  } ent_t;

  ent_t        mq[$];
  int unsigned issue_cnt = 0;
  bit          exp_map_valid = 1'b0;
  logic [0:0]  exp_map_id;
  logic [10:0] exp_map_dest;
  logic [31:0] exp_map_hash;
  logic [3:0]  exp_map_tag;
  bit          exp_unexp = 1'b0;

  always @(posedge clk) begin
    bit   acc;
    bit   rel;
    int   hit;
    ent_t e;
    if (!rst_n) begin
      mq.delete();
      issue_cnt     = 0;
      exp_map_valid = 1'b0;
      exp_unexp     = 1'b0;
    end else begin
      acc = s_req_valid && (mq.size() < 16);
      rel = (mq.size() > 0) && mq[0].resolved && m_ready;
      hit = -1;
      if (s_map_resp_valid) begin
        for (int i = 0; i < mq.size(); i++)
          if (hit < 0 && mq[i].tag == s_map_resp_tag && !mq[i].resolved) hit = i;
      end
      exp_unexp = s_map_resp_valid && (hit < 0);
      if (hit >= 0) begin
        e = mq[hit];
        e.resolved = 1'b1;
        e.q = s_map_resp_queue;
        mq[hit] = e;
      end
      if (rel) void'(mq.pop_front());
      exp_map_valid = acc;
      if (acc) begin
        exp_map_id   = s_req_id;
        exp_map_dest = s_req_dest;
        exp_map_hash = s_req_hash;
        exp_map_tag  = 4'(issue_cnt % 16);
        e.tag = exp_map_tag;
        e.user = s_req_user;
        e.resolved = 1'b0;
        e.q = '0;
        mq.push_back(e);
        issue_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    bit exp_v;
    if (chk_en) begin
      check("s_req_ready", 64'(s_req_ready), 64'(mq.size() != 16));
      check("outstanding", 64'(outstanding), 64'(mq.size()));
      exp_v = (mq.size() > 0) && mq[0].resolved;
      check("m_valid", 64'(m_valid), 64'(exp_v));
      if (exp_v) begin
        check("m_queue", 64'(m_queue), 64'(mq[0].q));
        check("m_user", 64'(m_user), 64'(mq[0].user));
      end
      check("m_map_req_valid", 64'(m_map_req_valid), 64'(exp_map_valid));
      if (exp_map_valid) begin
        check("m_map_req_id", 64'(m_map_req_id), 64'(exp_map_id));
        check("m_map_req_dest", 64'(m_map_req_dest), 64'(exp_map_dest));
        check("m_map_req_hash", 64'(m_map_req_hash), 64'(exp_map_hash));
        check("m_map_req_tag", 64'(m_map_req_tag), 64'(exp_map_tag));
      end
      check("stat_unexp_resp", 64'(stat_unexp_resp), 64'(exp_unexp));
    end
  end

  // All stimulus tasks are entered and left at a falling edge.
  task automatic apply_reset();
    s_req_valid = 1'b0;
    s_map_resp_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_req(input logic [10:0] dest, input logic [31:0] hash, input logic [15:0] user);
    s_req_id = 1'b0;
    s_req_dest = dest;
    s_req_hash = hash;
    s_req_user = user;
    s_req_valid = 1'b1;
    @(negedge clk);
    s_req_valid = 1'b0;
  endtask

  task automatic send_resp(input logic [9:0] q, input logic [3:0] tag);
    s_map_resp_queue = q;
    s_map_resp_tag = tag;
    s_map_resp_valid = 1'b1;
    @(negedge clk);
    s_map_resp_valid = 1'b0;
  endtask

  logic [3:0]  pend[$];
  logic [9:0]  hold_q;
  logic [15:0] hold_u;

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset s_req_ready", 64'(s_req_ready), 64'd1);
    check("reset outstanding", 64'(outstanding), 64'd0);
    rst_n = 1'b1;

    // Single request
    send_req(11'h005, 32'h1234, 16'hBEEF);
    check("single tag", 64'(m_map_req_tag), 64'd0);
    check("single hash", 64'(m_map_req_hash), 64'h1234);
    send_resp(10'h07, 4'd0);
    check("single m_valid", 64'(m_valid), 64'd1);
    check("single m_queue", 64'(m_queue), 64'h07);
    check("single m_user", 64'(m_user), 64'hBEEF);
    @(negedge clk);
    check("single drained", 64'(outstanding), 64'd0);

    // Fill all 16 tags
    apply_reset();
    for (int i = 0; i < 16; i++) send_req(11'(i), 32'(i * 3), 16'(16'h100 + i));
    check("fill ready", 64'(s_req_ready), 64'd0);
    check("fill outstanding", 64'(outstanding), 64'd16);
    send_resp(10'h2A, 4'd0);
    @(negedge clk);
    check("fill ready back", 64'(s_req_ready), 64'd1);
    send_req(11'h1, 32'hABCD, 16'h5555);
    check("fill wrap tag", 64'(m_map_req_tag), 64'd0);

    // Reorder: respond 2,0,1
    apply_reset();
    for (int i = 0; i < 3; i++) send_req(11'(i), 32'(i), 16'(16'hA0 + i));
    send_resp(10'h22, 4'd2);
    check("reorder blocked", 64'(m_valid), 64'd0);
    send_resp(10'h20, 4'd0);
    check("reorder first", 64'(m_queue), 64'h20);
    check("reorder gap", 64'(m_valid), 64'd1);
    @(negedge clk);
    check("reorder gap after 0", 64'(m_valid), 64'd0);
    send_resp(10'h21, 4'd1);
    check("reorder second", 64'(m_queue), 64'h21);
    @(negedge clk);
    check("reorder third", 64'(m_queue), 64'h22);
    @(negedge clk);
    check("reorder empty", 64'(m_valid), 64'd0);

    // Backpressure
    apply_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_req(11'(i), 32'(i), 16'(16'hC0 + i));
    for (int i = 0; i < 3; i++) send_resp(10'(10'h30 + i), 4'(i));
    hold_q = 10'h30;
    hold_u = 16'hC0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp stable queue", 64'(m_queue), 64'(hold_q));
      check("bp stable user", 64'(m_user), 64'(hold_u));
    end
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp drain valid", 64'(m_valid), 64'd1);
      check("bp drain queue", 64'(m_queue), 64'(10'h30 + i));
      @(negedge clk);
    end
    check("bp drained", 64'(m_valid), 64'd0);

    // Unexpected and duplicate responses
    apply_reset();
    m_ready = 1'b0;
    send_req(11'h3, 32'h77, 16'h1111);
    send_resp(10'h05, 4'd5);
    check("unexp tag5", 64'(stat_unexp_resp), 64'd1);
    send_resp(10'h11, 4'd0);
    check("unexp good", 64'(stat_unexp_resp), 64'd0);
    send_resp(10'h3FF, 4'd0);
    check("unexp dup", 64'(stat_unexp_resp), 64'd1);
    check("unexp keep queue", 64'(m_queue), 64'h11);
    check("unexp outstanding", 64'(outstanding), 64'd1);
    m_ready = 1'b1;

    // Reset mid-flight
    apply_reset();
    for (int i = 0; i < 4; i++) send_req(11'(i), 32'(i), 16'(i));
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      send_resp(10'(i), 4'(i));
      check("rst stale unexp", 64'(stat_unexp_resp), 64'd1);
      check("rst stale m_valid", 64'(m_valid), 64'd0);
    end
    check("rst outstanding", 64'(outstanding), 64'd0);

    // Randomized traffic with out-of-order responses and one reset
    apply_reset();
    pend.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int r;
      int idx;
      if (exp_map_valid) pend.push_back(exp_map_tag);
      s_req_valid = ($urandom_range(0, 99) < 60);
      s_req_id    = 1'($urandom);
      s_req_dest  = 11'($urandom);
      s_req_hash  = $urandom;
      s_req_user  = 16'($urandom);
      m_ready     = ($urandom_range(0, 99) < 70);
      s_map_resp_queue = 10'($urandom);
      s_map_resp_valid = 1'b0;
      r = int'($urandom_range(0, 99));
      if (r < 5) begin
        s_map_resp_tag = 4'($urandom);
        s_map_resp_valid = 1'b1;
      end else if (r < 55 && pend.size() > 0) begin
        idx = int'($urandom_range(0, pend.size() - 1));
        s_map_resp_tag = pend[idx];
        pend.delete(idx);
        s_map_resp_valid = 1'b1;
      end
      rst_n = (cyc != 1500);
      @(negedge clk);
    end
    rst_n = 1'b1;
    s_req_valid = 1'b0;
    m_ready = 1'b1;
    for (int cyc = 0; cyc < 120; cyc++) begin
      if (exp_map_valid) pend.push_back(exp_map_tag);
      s_map_resp_valid = 1'b0;
      if (pend.size() > 0) begin
        s_map_resp_tag = pend.pop_front();
        s_map_resp_queue = 10'($urandom);
        s_map_resp_valid = 1'b1;
      end
      @(negedge clk);
    end
    check("random final outstanding", 64'(outstanding), 64'd0);
    check("random final m_valid", 64'(m_valid), 64'd0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
